mbu_ctx_seq: RTL and testbench
==============================

// Module: mbu_ctx_seq
//
// PURPOSE
//   Context save/restore sequencer for the Memory Bank Unit's eight 8-bit bank registers (MB0-MB7).
//   On interrupt entry it reads all eight registers through the MBU read port into a LIFO shadow stack.
//   On interrupt return it writes them back through the MBU write port.
//   Sits between the Control Unit (save/restore strobes) and the MBU register file (ra/rd, wa/wd/nwen).
//   Holds the CU (nbusy) while it owns the MBU ports.
//
// PARAMETERS
//   DEPTH        4      shadow stack depth in contexts, 1..15 (each context = 8 bytes)
//   KERNEL_BASE  8'h80  base value loaded into MB[i] on save (KERNEL_BASE+i), macro-dependent
//
// PORTS
//   clk       in   1  system clock; all state changes on rising edge
//   nreset    in   1  asynchronous, active-low reset
//   nsave     in   1  active-low save request, sampled in IDLE only
//   nrestore  in   1  active-low restore request, sampled in IDLE only
//   rd        in   8  MBU register file read data (combinational from ra)
//   ra        out  3  MBU read address
//   wa        out  3  MBU write address
//   wd        out  8  MBU write data
//   nwen      out  1  active-low MBU write enable
//   nbusy     out  1  low while sequencing; CU stalls
//   ndone     out  1  low for exactly one cycle after a sequence completes
//   nfault    out  1  sticky active-low overflow/underflow flag; cleared only by nreset
//   sp        out  4  current stack depth (0..DEPTH)
//
// BEHAVIOUR
//   Reset (async, nreset low)
//     - nbusy=1, ndone=1, nfault=1, nwen=1, ra=0, wa=0, wd=0, sp=0; state IDLE.
//     - Stack contents undefined.
//     - Reset mid-sequence aborts it; nwen goes high asynchronously; no partial context is retained.
//   All outputs are registered.
//   Index counter idx[2:0] runs 0..7; wraps only via end-of-sequence.
//   States: IDLE, SV_RD, SV_WR, RS_WR, DONE.
//   IDLE
//     - nsave low and sp<DEPTH: idx=0, nbusy=0, go to SV_RD.
//     - nsave low and sp==DEPTH: nfault=0; stay IDLE; no MBU access.
//     - else nrestore low and sp>0: sp=sp-1, idx=0, nbusy=0, go to RS_WR.
//     - else nrestore low and sp==0: nfault=0; stay IDLE.
//     - nsave and nrestore both low: save wins, restore dropped.
//   SV_RD
//     - ra=idx for the whole cycle.
//     - At the closing edge, rd is captured into stack[sp][idx].
//   SV_WR (only with macro; see CONFIGURATION)
//     - wa=idx, wd=KERNEL_BASE+idx (8-bit, modulo 256), nwen=0 for one full cycle.
//     - idx then increments; next state SV_RD.
//   Save end
//     - After idx=7 completes: sp=sp+1, go to DONE.
//   RS_WR
//     - wa=idx, wd=stack[sp][idx], nwen=0 for one full cycle.
//     - wa and wd are stable the entire cycle nwen is low.
//     - After idx=7: go to DONE.
//   DONE
//     - ndone=0 and nbusy=1 for one cycle; next state IDLE.
//     - nwen=1 and ra=0 in DONE and IDLE.
//   Requests asserted while not in IDLE are ignored and never queued.
//   A request still held low when IDLE is re-entered starts a new sequence.
//   Latency from request edge to first MBU access: 1 cycle.
//   Restore: 8 WR cycles + DONE.
//   LIFO: the most recently saved context restores first.
//
// CONFIGURATION
//   MBU_CTX_KERNEL_MAP_EN defined
//     - Save interleaves SV_RD/SV_WR per register: 16 cycles + DONE.
//     - MB[i] is left equal to KERNEL_BASE+i after save.
//   MBU_CTX_KERNEL_MAP_EN undefined
//     - Save is SV_RD only: 8 cycles + DONE.
//     - nwen stays high throughout save; MBU contents are unchanged.
//     - KERNEL_BASE is unused.
//   Restore behaviour is identical in both builds.
//
// TESTING
//   1. MB0-7 = 11..18, pulse nsave
//      -> ra steps 0..7; sp=1; ndone low one cycle.
//      -> With macro: MB[i]=80+i.
//      -> Without macro: nwen never low; 8 busy cycles.
//   2. After 1, pulse nrestore
//      -> 8 nwen-low cycles, wa 0..7, wd 11..18; sp=0; MB0-7 = 11..18.
//   3. Save contexts A (01..08) then B (21..28), restore twice
//      -> B returned first, then A; sp goes 2,1,0.
//   4. DEPTH=4 with sp=4, nsave
//      -> nfault=0, no ra/nwen activity, sp stays 4.
//      -> Then with sp=0, nrestore: nfault stays 0, no writes.
//   5. nsave and nrestore low same IDLE cycle
//      -> save runs.
//      -> nrestore pulsed during busy: ignored, no second sequence.
//   6. nreset low during RS_WR idx=3
//      -> nwen=1 immediately, sp=0, nbusy=1, nfault=1.

Source files
------------

// File: rtl/mbu_ctx_seq.sv
// Context save/restore sequencer for MBU bank registers MB0-MB7 backed by a LIFO shadow stack.
// Optional feature macro: MBU_CTX_KERNEL_MAP_EN (save also writes MB[i] = KERNEL_BASE+i).
module mbu_ctx_seq #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] KERNEL_BASE = 8'h80
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       nsave,
  input  logic       nrestore,
  input  logic [7:0] rd,
  output logic [2:0] ra,
  output logic [2:0] wa,
  output logic [7:0] wd,
  output logic       nwen,
  output logic       nbusy,
  output logic       ndone,
  output logic       nfault,
  output logic [3:0] sp
);

  typedef enum logic [2:0] {IDLE, SV_RD, SV_WR, RS_WR, DONE} state_t;

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] sp_q, sp_d;
  logic [2:0] ra_q, ra_d;
  logic [2:0] wa_q, wa_d;
  logic [7:0] wd_q, wd_d;
  logic       nwen_q, nwen_d;
  logic       nbusy_q, nbusy_d;
  logic       ndone_q, ndone_d;
  logic       nfault_q, nfault_d;

  // Addressed as {sp, idx}; slots at or above DEPTH are never written.
  logic [7:0] stack_q [128];
  logic       stack_we;
  logic [6:0] stack_waddr;
  logic [3:0] sp_dec;
  logic [2:0] idx_inc;

  assign sp_dec      = sp_q - 4'd1;
  assign idx_inc     = idx_q + 3'd1;
  assign stack_waddr = {sp_q, idx_q};

`ifdef MBU_CTX_KERNEL_MAP_EN
  logic [7:0] kernel_wd;
  assign kernel_wd = KERNEL_BASE + {5'd0, idx_q};
`else
  logic [7:0] unused_kernel_base;
  assign unused_kernel_base = KERNEL_BASE;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sp_d     = sp_q;
    ra_d     = ra_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    nwen_d   = 1'b1;
    nbusy_d  = nbusy_q;
    ndone_d  = 1'b1;
    nfault_d = nfault_q;
    stack_we = 1'b0;
    case (state_q)
      IDLE: begin
        ra_d    = 3'd0;
        nbusy_d = 1'b1;
        if (!nsave) begin
          if (sp_q < DEPTH_L) begin
            idx_d   = 3'd0;
            nbusy_d = 1'b0;
            state_d = SV_RD;
          end else begin
            nfault_d = 1'b0;
          end
        end else if (!nrestore) begin
          if (sp_q != 4'd0) begin
            sp_d    = sp_dec;
            idx_d   = 3'd0;
            nbusy_d = 1'b0;
            wa_d    = 3'd0;
            wd_d    = stack_q[{sp_dec, 3'd0}];
            nwen_d  = 1'b0;
            state_d = RS_WR;
          end else begin
            nfault_d = 1'b0;
          end
        end
      end
      SV_RD: begin
        stack_we = 1'b1;
`ifdef MBU_CTX_KERNEL_MAP_EN
        wa_d    = idx_q;
        wd_d    = kernel_wd;
        nwen_d  = 1'b0;
        state_d = SV_WR;
      end
      SV_WR: begin
`endif
        // Per-register step of a save; the last register pushes the context.
        if (idx_q == 3'd7) begin
          sp_d    = sp_q + 4'd1;
          ra_d    = 3'd0;
          nbusy_d = 1'b1;
          ndone_d = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_inc;
          ra_d    = idx_inc;
          state_d = SV_RD;
        end
      end
      RS_WR: begin
        if (idx_q == 3'd7) begin
          nbusy_d = 1'b1;
          ndone_d = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_inc;
          wa_d    = idx_inc;
          wd_d    = stack_q[{sp_q, idx_inc}];
          nwen_d  = 1'b0;
        end
      end
      DONE: begin
        ra_d    = 3'd0;
        nbusy_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      sp_q     <= 4'd0;
      ra_q     <= 3'd0;
      wa_q     <= 3'd0;
      wd_q     <= 8'd0;
      nwen_q   <= 1'b1;
      nbusy_q  <= 1'b1;
      ndone_q  <= 1'b1;
      nfault_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sp_q     <= sp_d;
      ra_q     <= ra_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      nwen_q   <= nwen_d;
      nbusy_q  <= nbusy_d;
      ndone_q  <= ndone_d;
      nfault_q <= nfault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stack_we) stack_q[stack_waddr] <= rd;
  end

  assign ra     = ra_q;
  assign wa     = wa_q;
  assign wd     = wd_q;
  assign nwen   = nwen_q;
  assign nbusy  = nbusy_q;
  assign ndone  = ndone_q;
  assign nfault = nfault_q;
  assign sp     = sp_q;

endmodule

// File: tb/tb_mbu_ctx_seq.sv
// Self-checking bench for mbu_ctx_seq: scripted vector table, corner sequences and random ops
// checked against a context-queue reference model and an MBU register file model.
module tb_mbu_ctx_seq;

  localparam int         DEPTH = 4;
  localparam logic [7:0] KBASE = 8'h80;
`ifdef MBU_CTX_KERNEL_MAP_EN
  localparam bit KMAP = 1'b1;
`else
  localparam bit KMAP = 1'b0;
`endif

  typedef struct {
    logic       nsave;
    logic       nrestore;
    bit         loadMb;
    logic [7:0] base;
    logic [3:0] expSp;
    logic       expNfault;
  } vec_t;

  logic       clk = 1'b0;
  logic       nreset;
  logic       nsave;
  logic       nrestore;
  logic [7:0] rd;
  logic [2:0] ra;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       nwen;
  logic       nbusy;
  logic       ndone;
  logic       nfault;
  logic [3:0] sp;

  logic [7:0]  mb [8];
  logic        loadNow;
  logic [63:0] loadVal;
  logic [63:0] ctxQ [$];
  logic        refFault;
  vec_t        vecs [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mbu_ctx_seq #(.DEPTH(DEPTH), .KERNEL_BASE(KBASE)) dut (
    .clk(clk), .nreset(nreset), .nsave(nsave), .nrestore(nrestore), .rd(rd),
    .ra(ra), .wa(wa), .wd(wd), .nwen(nwen), .nbusy(nbusy), .ndone(ndone),
    .nfault(nfault), .sp(sp)
  );

  // MBU register file: combinational read, write on rising edge while nwen is low.
  assign rd = mb[ra];
  always @(posedge clk) begin
    if (loadNow) begin
      for (int i = 0; i < 8; i++) mb[i] <= loadVal[i*8 +: 8];
    end else if (!nwen) begin
      mb[wa] <= wd;
    end
  end

  function automatic logic [63:0] packMb();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mb[i];
    return v;
  endfunction

  function automatic logic [63:0] ramp(input logic [7:0] base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  function automatic vec_t mkVec(input logic s, input logic r, input bit ld,
                                 input logic [7:0] base, input logic [3:0] esp, input logic ef);
    vec_t v;
    v.nsave = s; v.nrestore = r; v.loadMb = ld; v.base = base; v.expSp = esp; v.expNfault = ef;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    nsave    = s;
    nrestore = r;
  endtask

  task automatic loadMbRegs(input logic [63:0] v);
    @(negedge clk);
    loadVal = v;
    loadNow = 1'b1;
    @(negedge clk);
    loadNow = 1'b0;
  endtask

  // One request pulse from IDLE, observed over a fixed window and compared with the model.
  task automatic runOp(input logic s, input logic r, input bit poke);
    logic [63:0] pre, expMb, ctx;
    logic [23:0] expRv, actRv;
    logic [87:0] expWv, actWv;
    int expBusy, expDone, expReads, expWrites;
    int busy, done, reads, writes;
    pre = packMb(); expMb = pre;
    expBusy = 0; expDone = 0; expReads = 0; expWrites = 0; expRv = '0; expWv = '0;
    if (!s) begin
      if (ctxQ.size() < DEPTH) begin
        ctxQ.push_back(pre);
        expBusy = KMAP ? 16 : 8; expDone = 1; expReads = 8;
        for (int i = 0; i < 8; i++) expRv = {expRv[20:0], 3'(i)};
        if (KMAP) begin
          expWrites = 8;
          for (int i = 0; i < 8; i++) expWv = {expWv[76:0], 3'(i), KBASE + 8'(i)};
          expMb = ramp(KBASE);
        end
      end else refFault = 1'b0;
    end else if (!r) begin
      if (ctxQ.size() > 0) begin
        ctx = ctxQ.pop_back();
        expBusy = 8; expDone = 1; expWrites = 8;
        for (int i = 0; i < 8; i++) expWv = {expWv[76:0], 3'(i), ctx[i*8 +: 8]};
        expMb = ctx;
      end else refFault = 1'b0;
    end
    @(negedge clk);
    applyStimulus(s, r);
    busy = 0; done = 0; reads = 0; writes = 0; actRv = '0; actWv = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) applyStimulus(1'b1, 1'b1);
      if (poke && k == 3) applyStimulus(1'b1, 1'b0);
      if (poke && k == 5) applyStimulus(1'b1, 1'b1);
      if (!nbusy) busy++;
      if (!ndone) done++;
      if (!nbusy && nwen) begin reads++; actRv = {actRv[20:0], ra}; end
      if (!nwen) begin writes++; actWv = {actWv[76:0], wa, wd}; end
    end
    checkOutput("busyCycles", 128'(busy), 128'(expBusy));
    checkOutput("ndonePulses", 128'(done), 128'(expDone));
    checkOutput("readSeq", {72'(reads), 32'd0, actRv}, {72'(expReads), 32'd0, expRv});
    checkOutput("writeSeq", {32'(writes), 8'd0, actWv}, {32'(expWrites), 8'd0, expWv});
    checkOutput("mbContents", 128'(packMb()), 128'(expMb));
    checkOutput("spModel", 128'(sp), 128'(ctxQ.size()));
    checkOutput("nfaultModel", 128'(nfault), 128'(refFault));
    checkOutput("raIdle", 128'(ra), 128'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int op;
    nreset = 1'b0; loadNow = 1'b0; loadVal = '0; refFault = 1'b1;
    applyStimulus(1'b1, 1'b1);
    #12;
    checkOutput("rstFlags", 128'({nbusy, ndone, nfault, nwen}), 128'(4'hF));
    checkOutput("rstRaWa", 128'({ra, wa}), 128'd0);
    checkOutput("rstWd", 128'(wd), 128'd0);
    checkOutput("rstSp", 128'(sp), 128'd0);
    @(negedge clk);
    nreset = 1'b1;

    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h11, 4'd1, 1'b1));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h21, 4'd2, 1'b1));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 8'h31, 4'd1, 1'b1));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h41, 4'd1, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h51, 4'd2, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h61, 4'd3, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h71, 4'd4, 1'b1));
    vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 8'h81, 4'd4, 1'b0));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd3, 1'b0));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd2, 1'b0));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0));
    vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].loadMb) loadMbRegs(ramp(vecs[i].base));
      runOp(vecs[i].nsave, vecs[i].nrestore, 1'b0);
      checkOutput($sformatf("vec%0d sp", i), 128'(sp), 128'(vecs[i].expSp));
      checkOutput($sformatf("vec%0d nfault", i), 128'(nfault), 128'(vecs[i].expNfault));
    end

    // Restore request during a busy save must be dropped.
    loadMbRegs(ramp(8'h91));
    runOp(1'b0, 1'b1, 1'b1);
    checkOutput("pokeSp", 128'(sp), 128'd1);

    // Reset in the middle of a restore, at register 3.
    @(negedge clk); applyStimulus(1'b1, 1'b0);
    @(negedge clk); applyStimulus(1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (!nwen && wa == 3'd3) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("rstWaitIdx3", 128'(found), 128'd1);
    #2 nreset = 1'b0;
    #1;
    checkOutput("midRstNwen", 128'(nwen), 128'd1);
    checkOutput("midRstNbusy", 128'(nbusy), 128'd1);
    checkOutput("midRstSp", 128'(sp), 128'd0);
    checkOutput("midRstNfault", 128'(nfault), 128'd1);
    ctxQ.delete(); refFault = 1'b1;
    @(negedge clk); nreset = 1'b1;
    runOp(1'b1, 1'b0, 1'b0);

    @(negedge clk); nreset = 1'b0;
    @(negedge clk); nreset = 1'b1;
    ctxQ.delete(); refFault = 1'b1;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      if (op != 2) loadMbRegs({$urandom, $urandom});
      runOp((op == 2) ? 1'b1 : 1'b0, (op >= 2) ? 1'b0 : 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
